// File: rtl/demux_nbit_1x4_buf_if.sv
// Producer/consumer bundle for the registered 1:4 demux; producer and consumers
// sit on the master side, the demux itself on the slave side.
interface demux_nbit_1x4_buf_if #(
  parameter int bus_size  = 16,
  parameter int cnt_width = 16
);
  logic [bus_size-1:0]   in_data;
  logic [1:0]            in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [4*bus_size-1:0] out_data;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [cnt_width-1:0]  acc_count;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, acc_count
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, acc_count
  );
endinterface

// File: rtl/demux_nbit_1x4_buf.sv
// Registered 1:4 demux with a one-word buffer per channel; 1-cycle latency.
// A full, undrained channel stalls only words addressed to it (head-of-line on the input).
module demux_nbit_1x4_buf #(
  parameter int bus_size  = 16,
  parameter int cnt_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_nbit_1x4_buf_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t            state_q [4];
  ch_state_t            state_d [4];
  logic [bus_size-1:0]  data_q  [4];
  logic [bus_size-1:0]  data_d  [4];
  logic [cnt_width-1:0] cnt_q;
  logic [cnt_width-1:0] cnt_d;
  logic [3:0]           valid;
  logic                 accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  // Ready looks only at the addressed channel, so in_valid never feeds back into it.
  assign bus.in_ready = ~valid[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      case (state_q[k])
        EMPTY: begin
          if (accept && (bus.in_sel == 2'(k))) begin
            state_d[k] = FULL;
            data_d[k]  = bus.in_data;
          end
        end
        FULL: begin
          // A load into a draining channel replaces the word and stays FULL.
          if (accept && (bus.in_sel == 2'(k))) begin
            data_d[k] = bus.in_data;
          end else if (bus.out_ready[k]) begin
            state_d[k] = EMPTY;
          end
        end
        default: state_d[k] = EMPTY;
      endcase
    end
    if (accept) begin
      cnt_d = cnt_q + cnt_width'(1);
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_out
    assign valid[k]                               = (state_q[k] == FULL);
    assign bus.out_data[k*bus_size +: bus_size]   = data_q[k];
  end

  assign bus.out_valid = valid;
  assign bus.acc_count = cnt_q;

endmodule
